// File: rtl/program_mem_if.sv
// rtl/program_mem_if.sv - fetch and loader signal bundle for the writable program memory
interface program_mem_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  fetch_en;
    logic [DATA_WIDTH-1:0] instruction;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_last;
    logic                  load_ready;
    logic                  load_start;
    logic                  run;
    logic [ADDR_WIDTH:0]   prog_len;

    modport master (
        output address, fetch_en, load_valid, load_data, load_last, load_start,
        input  instruction, load_ready, run, prog_len
    );

    modport slave (
        input  address, fetch_en, load_valid, load_data, load_last, load_start,
        output instruction, load_ready, run, prog_len
    );
endinterface

// File: rtl/program_mem.sv
// rtl/program_mem.sv - writable program memory: clear to NOP, load image, serve registered fetches
module program_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input logic            clk,
    input logic            reset,
    program_mem_if.slave   bus
);
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   FULL_LEN  = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state, next_state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] clr_ptr, wr_ptr;
    logic [ADDR_WIDTH:0]   prog_len_q;
    logic [DATA_WIDTH-1:0] instr_q;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  accept;
    logic                  reload;

    // Ready and run are pure state decodes so they are glitch-free after the state flop
    assign bus.load_ready  = (state == LOAD);
    assign bus.run         = (state == RUN);
    assign bus.instruction = instr_q;
    assign bus.prog_len    = prog_len_q;
    assign reload          = (state == RUN) && bus.load_start;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus the single shared write port (clear writes zero, load writes the stream word)
    always_comb begin
        next_state = state;
        mem_we     = 1'b0;
        mem_waddr  = clr_ptr;
        mem_wdata  = '0;
        accept     = 1'b0;
        case (state)
            CLEAR: begin
                mem_we = 1'b1;
                if (clr_ptr == LAST_ADDR) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (bus.load_valid) begin
                    accept    = 1'b1;
                    mem_we    = 1'b1;
                    mem_waddr = wr_ptr;
                    mem_wdata = bus.load_data;
                    if (bus.load_last || (wr_ptr == LAST_ADDR)) begin
                        next_state = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.load_start) begin
                    next_state = CLEAR;
                end
            end
            default: next_state = CLEAR;
        endcase
    end

    // Storage array kept free of reset so it maps onto RAM; clearing is done by the CLEAR pass
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Pointers, image length and the registered fetch port
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_ptr    <= '0;
            wr_ptr     <= '0;
            prog_len_q <= '0;
            instr_q    <= '0;
        end else begin
            if (state == CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
            end
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (prog_len_q != FULL_LEN) begin
                    prog_len_q <= prog_len_q + 1'b1;
                end
            end
            if (reload) begin
                clr_ptr    <= '0;
                wr_ptr     <= '0;
                prog_len_q <= '0;
            end
            // A stalled PC outside RUN must see NOPs; a reload also discards that cycle's fetch
            if ((state != RUN) || reload) begin
                instr_q <= '0;
            end else if (bus.fetch_en) begin
                instr_q <= mem[bus.address];
            end
        end
    end
endmodule

// File: tb/tb_program_mem.sv
// tb/tb_program_mem.sv - directed and randomized checks of program_mem against an image-queue model
module tb_program_mem;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: the accepted image in order; every other location reads as NOP
    logic [15:0] img[$];
    bit          m_load;

    program_mem_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus ();

    program_mem #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input int a);
        return (a < img.size()) ? img[a] : 16'h0000;
    endfunction

    // Called right after the edge that enters CLEAR: expect 16 busy cycles, then ready
    task automatic do_clear();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("clear_busy_%0d", i), {30'd0, bus.run, bus.load_ready}, 32'd0);
            tick();
        end
        check("clear_done_ready", {31'd0, bus.load_ready}, 32'd1);
        check("clear_done_run", {31'd0, bus.run}, 32'd0);
        img.delete();
        m_load = 1'b1;
    endtask

    task automatic send_word(input logic [15:0] d, input bit last);
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        bus.load_last  = last;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        if (m_load) begin
            img.push_back(d);
            if (last || img.size() == 16) m_load = 1'b0;
        end
    endtask

    task automatic fetch(input int a);
        bus.fetch_en = 1'b1;
        bus.address  = 4'(a);
        tick();
        bus.fetch_en = 1'b0;
        check($sformatf("fetch_addr_%0d", a), {16'd0, bus.instruction}, {16'd0, exp_word(a)});
    endtask

    task automatic fetch_all();
        for (int a = 0; a < 16; a++) fetch(a);
    endtask

    task automatic reload();
        bus.load_start = 1'b1;
        bus.fetch_en   = 1'b1;
        bus.address    = 4'd2;
        tick();
        bus.fetch_en   = 1'b0;
        check("reload_instr_zero", {16'd0, bus.instruction}, 32'd0);
        check("reload_prog_len", {27'd0, bus.prog_len}, 32'd0);
        // load_start held through CLEAR and into LOAD must have no effect there
        do_clear();
        bus.load_start = 1'b0;
    endtask

    initial begin
        logic [15:0] short_img [4];
        int sent;
        short_img[0] = 16'h1E09; short_img[1] = 16'h100A;
        short_img[2] = 16'hF000; short_img[3] = 16'hE1C0;
        reset = 1'b1;
        bus.address = '0; bus.fetch_en = 1'b0; bus.load_valid = 1'b0;
        bus.load_data = '0; bus.load_last = 1'b0; bus.load_start = 1'b0;
        m_load = 1'b0;

        // Reset state and the 16-cycle clear pass
        tick();
        reset = 1'b0;
        check("rst_instruction", {16'd0, bus.instruction}, 32'd0);
        check("rst_prog_len", {27'd0, bus.prog_len}, 32'd0);
        do_clear();

        // Fetch while loading must still yield NOP
        bus.fetch_en = 1'b1; bus.address = 4'd5;
        tick();
        bus.fetch_en = 1'b0;
        check("load_fetch_nop", {16'd0, bus.instruction}, 32'd0);
        check("load_still_ready", {31'd0, bus.load_ready}, 32'd1);

        // Short image terminated by load_last
        for (int i = 0; i < 4; i++) send_word(short_img[i], i == 3);
        check("short_run", {31'd0, bus.run}, 32'd1);
        check("short_ready_low", {31'd0, bus.load_ready}, 32'd0);
        check("short_prog_len", {27'd0, bus.prog_len}, 32'd4);
        fetch(1);
        check("short_addr1_const", {16'd0, bus.instruction}, 32'h100A);
        fetch(9);

        // Fetch hold with a wandering address, then a single-cycle fetch of addr 3
        fetch(0);
        for (int i = 0; i < 5; i++) begin
            bus.address = 4'($urandom);
            tick();
            check("hold_instr", {16'd0, bus.instruction}, {16'd0, exp_word(0)});
        end
        fetch(3);
        check("hold_addr3_const", {16'd0, bus.instruction}, 32'hE1C0);

        // Full image without load_last, then a 17th word that must be dropped
        reload();
        for (int i = 0; i < 16; i++) send_word(16'($urandom), 1'b0);
        check("full_run", {31'd0, bus.run}, 32'd1);
        check("full_prog_len", {27'd0, bus.prog_len}, 32'd16);
        check("full_ready_low", {31'd0, bus.load_ready}, 32'd0);
        send_word(16'($urandom), 1'b1);
        check("full_prog_len_after17", {27'd0, bus.prog_len}, 32'd16);
        fetch_all();

        // Backpressure: random gaps with stray data and load_last on idle cycles
        reload();
        sent = 0;
        while (sent < 6) begin
            if ($urandom_range(0, 1) == 1) begin
                send_word(16'($urandom), sent == 5);
                sent++;
            end else begin
                bus.load_data = 16'($urandom);
                bus.load_last = 1'($urandom);
                tick();
                bus.load_last = 1'b0;
            end
        end
        check("bp_run", {31'd0, bus.run}, 32'd1);
        check("bp_prog_len", {27'd0, bus.prog_len}, 32'd6);
        fetch_all();

        // Reset in the middle of a load
        reload();
        send_word(16'($urandom), 1'b0);
        send_word(16'($urandom), 1'b0);
        check("midload_prog_len", {27'd0, bus.prog_len}, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_prog_len", {27'd0, bus.prog_len}, 32'd0);
        check("midrst_instr", {16'd0, bus.instruction}, 32'd0);
        do_clear();
        send_word(16'($urandom), 1'b1);
        check("post_rst_run", {31'd0, bus.run}, 32'd1);
        check("post_rst_prog_len", {27'd0, bus.prog_len}, 32'd1);
        fetch_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
